exec_ctrl: RTL

Multi-cycle execute controller and register file that sits directly upstream of the registered 8-bit ALU.
- Accepts one 16-bit instruction per transaction over a valid/ready handshake.
- Reads operands from a 4-entry x 8-bit register file and drives the ALU operand and opcode inputs.
- Waits for the ALU's one-cycle registered result, then writes it back and updates a zero flag.
- Completes one instruction every 3 cycles.

---
 rtl/exec_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/exec_ctrl.sv
//==============================================================================
// Module      : exec_ctrl
// Description : Three-cycle execute controller with a small register file,
//               driving a registered ALU and writing its result back.
//               Optional build macro EXEC_CTRL_R0_ZERO_EN hardwires R0 to zero.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module exec_ctrl #(
    parameter int DATA_W = 8,
    parameter int NREG_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instr,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_op,
    input  logic [DATA_W-1:0] alu_y,
    output logic              wb_valid,
    output logic [NREG_W-1:0] wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              zero_flag,
    input  logic [NREG_W-1:0] dbg_rsel,
    output logic [DATA_W-1:0] dbg_rdata
);

    localparam int C_NREG = 1 << NREG_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_ready;
    logic [DATA_W-1:0]   r_regs [C_NREG];
    logic [DATA_W-1:0]   r_alu_a;
    logic [DATA_W-1:0]   r_alu_b;
    logic [2:0]          r_alu_op;
    logic [NREG_W-1:0]   r_rd;
    logic                r_wb_valid;
    logic [NREG_W-1:0]   r_wb_rd;
    logic [DATA_W-1:0]   r_wb_data;
    logic                r_zero;

    // Instruction field decode
    logic [2:0]          w_op;
    logic                w_imm;
    logic [NREG_W-1:0]   w_rd;
    logic [NREG_W-1:0]   w_rs1;
    logic [NREG_W-1:0]   w_rs2;
    logic [DATA_W-1:0]   w_imm8;
    logic                w_wr_en;

    assign w_op   = instr[15:13];
    assign w_imm  = instr[12];
    assign w_rd   = instr[10 +: NREG_W];
    assign w_rs1  = instr[8 +: NREG_W];
    assign w_rs2  = instr[0 +: NREG_W];
    assign w_imm8 = DATA_W'(instr[7:0]);

`ifdef EXEC_CTRL_R0_ZERO_EN
    assign w_wr_en   = (r_rd != '0);
    assign dbg_rdata = (dbg_rsel == '0) ? '0 : r_regs[dbg_rsel];
`else
    assign w_wr_en   = 1'b1;
    assign dbg_rdata = r_regs[dbg_rsel];
`endif

    // Writes only happen in WB and accepts only in IDLE, so operand reads at
    // the accept edge always observe the previous instruction's result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_ready    <= 1'b1;
            for (int i = 0; i < C_NREG; i++) begin
                r_regs[i] <= '0;
            end
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_op   <= '0;
            r_rd       <= '0;
            r_wb_valid <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_data  <= '0;
            r_zero     <= 1'b0;
        end else begin
            r_wb_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (instr_valid) begin
                        r_alu_a  <= r_regs[w_rs1];
                        r_alu_b  <= w_imm ? w_imm8 : r_regs[w_rs2];
                        r_alu_op <= w_op;
                        r_rd     <= w_rd;
                        r_ready  <= 1'b0;
                        r_state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_state <= S_WB;
                end
                S_WB: begin
                    if (w_wr_en) begin
                        r_regs[r_rd] <= alu_y;
                    end
                    r_wb_valid <= 1'b1;
                    r_wb_rd    <= r_rd;
                    r_wb_data  <= alu_y;
                    r_zero     <= (alu_y == '0);
                    r_ready    <= 1'b1;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign instr_ready = r_ready;
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_op      = r_alu_op;
    assign wb_valid    = r_wb_valid;
    assign wb_rd       = r_wb_rd;
    assign wb_data     = r_wb_data;
    assign zero_flag   = r_zero;

endmodule

`default_nettype wire
